// File: rtl/conv_pkg.sv
// Shared definitions for the conv_unit loader path: FSM state encoding and
// bit offsets of the packed layer parameter word.
package conv_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_PARA = 3'd1,
      ST_WEI  = 3'd2,
      ST_FTM  = 3'd3,
      ST_DONE = 3'd4
   } state_e;

   // Field layout of the layer parameter word, decoded again inside conv_unit.
   localparam int unsigned PARA_STRIDE_LSB = 0;
   localparam int unsigned PARA_STRIDE_W   = 2;
   localparam int unsigned PARA_PAD_LSB    = 2;
   localparam int unsigned PARA_PAD_W      = 2;
   localparam int unsigned PARA_WSHAPE_LSB = 4;
   localparam int unsigned PARA_WSHAPE_W   = 16;
   localparam int unsigned PARA_FSHAPE_LSB = 20;
   localparam int unsigned PARA_FSHAPE_W   = 32;

   function automatic int unsigned kcnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/stream_word_counter.sv
// Loadable down-counter tracking the remaining beats of one stream segment;
// is_last_o flags the final beat so the owner can reload or exit in time.
module stream_word_counter #(
   parameter int unsigned W = 20
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         dec_i,
   output logic         is_last_o
);

   logic [W-1:0] count_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         count_q <= '0;
      end else if (load_i) begin
         count_q <= load_val_i;
      end else if (dec_i && (count_q != '0)) begin
         count_q <= count_q - 1'b1;
      end
   end

   assign is_last_o = (count_q == W'(1));

endmodule

// File: rtl/conv_loader.sv
// Streams one layer (parameter word, N_KERNEL weight kernels, feature map)
// from the DMA read stream into the conv_unit write ports.
module conv_loader
   import conv_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned B_PARA     = 64,
   parameter int unsigned B_WORDS    = 20,
   parameter int unsigned N_KERNEL   = 4
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [B_PARA-1:0]     cmd_para,
   input  logic [B_WORDS-1:0]    cmd_wei_words,
   input  logic [B_WORDS-1:0]    cmd_ftm_words,
   input  logic                  s_tvalid,
   output logic                  s_tready,
   input  logic [DATA_WIDTH-1:0] s_tdata,
   input  logic                  s_tlast,
   output logic [B_PARA-1:0]     para,
   output logic                  para_we,
   output logic                  wb_clr,
   output logic                  wb_we,
   output logic                  fb_clr,
   output logic                  fb_we,
   output logic [DATA_WIDTH-1:0] di,
   input  logic                  wb_full,
   input  logic                  fb_full,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam int unsigned KW = kcnt_width(N_KERNEL);

   state_e                state_q;
   logic                  cmd_ready_q;
   logic                  busy_q;
   logic                  done_q;
   logic                  err_q;
   logic                  para_we_q;
   logic                  wb_clr_q;
   logic                  fb_clr_q;
   logic                  wb_we_q;
   logic                  fb_we_q;
   logic [B_PARA-1:0]     para_q;
   logic [DATA_WIDTH-1:0] di_q;
   logic [B_WORDS-1:0]    wei_words_q;
   logic [B_WORDS-1:0]    ftm_words_q;
   logic [KW-1:0]         kcnt_q;

   logic tready_c;
   logic wei_beat_c;
   logic ftm_beat_c;
   logic last_kernel_c;
   logic wcnt_load_c;
   logic fcnt_load_c;
   logic wcnt_last;
   logic fcnt_last;

   always_comb begin
      tready_c      = ((state_q == ST_WEI) && !wb_full) ||
                      ((state_q == ST_FTM) && !fb_full);
      wei_beat_c    = s_tvalid && tready_c && (state_q == ST_WEI);
      ftm_beat_c    = s_tvalid && tready_c && (state_q == ST_FTM);
      last_kernel_c = (kcnt_q == KW'(N_KERNEL - 1));
      // wcnt reloads between kernels; fcnt loads once, either straight from
      // PARA (no weights) or on the final beat of the last kernel.
      wcnt_load_c   = (state_q == ST_PARA) ||
                      (wei_beat_c && wcnt_last && !last_kernel_c);
      fcnt_load_c   = ((state_q == ST_PARA) && (wei_words_q == '0)) ||
                      (wei_beat_c && wcnt_last && last_kernel_c);
   end

   stream_word_counter #(.W(B_WORDS)) u_wcnt (
      .clk        (clk),
      .rstn       (rstn),
      .load_i     (wcnt_load_c),
      .load_val_i (wei_words_q),
      .dec_i      (wei_beat_c),
      .is_last_o  (wcnt_last)
   );

   stream_word_counter #(.W(B_WORDS)) u_fcnt (
      .clk        (clk),
      .rstn       (rstn),
      .load_i     (fcnt_load_c),
      .load_val_i (ftm_words_q),
      .dec_i      (ftm_beat_c),
      .is_last_o  (fcnt_last)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= ST_IDLE;
         cmd_ready_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         para_we_q   <= 1'b0;
         wb_clr_q    <= 1'b0;
         fb_clr_q    <= 1'b0;
         wb_we_q     <= 1'b0;
         fb_we_q     <= 1'b0;
         para_q      <= '0;
         di_q        <= '0;
         wei_words_q <= '0;
         ftm_words_q <= '0;
         kcnt_q      <= '0;
      end else begin
         // Pulses are registered from the state they belong to, so done lands
         // the cycle after the last buffer write rather than alongside it.
         para_we_q <= (state_q == ST_PARA);
         wb_clr_q  <= (state_q == ST_PARA);
         fb_clr_q  <= (state_q == ST_PARA);
         done_q    <= (state_q == ST_DONE);
         wb_we_q   <= wei_beat_c;
         fb_we_q   <= ftm_beat_c;
         if (wei_beat_c || ftm_beat_c) begin
            di_q <= s_tdata;
         end

         case (state_q)
            ST_IDLE: begin
               cmd_ready_q <= 1'b1;
               if (cmd_ready_q && cmd_valid) begin
                  para_q      <= cmd_para;
                  wei_words_q <= cmd_wei_words;
                  ftm_words_q <= cmd_ftm_words;
                  err_q       <= 1'b0;
                  cmd_ready_q <= 1'b0;
                  busy_q      <= 1'b1;
                  state_q     <= ST_PARA;
               end
            end
            ST_PARA: begin
               kcnt_q <= '0;
               if (wei_words_q != '0) begin
                  state_q <= ST_WEI;
               end else if (ftm_words_q != '0) begin
                  state_q <= ST_FTM;
               end else begin
                  state_q <= ST_DONE;
               end
            end
            ST_WEI: begin
               if (wei_beat_c) begin
                  if (s_tlast) begin
                     err_q <= 1'b1;
                  end
                  if (wcnt_last) begin
                     if (last_kernel_c) begin
                        state_q <= (ftm_words_q != '0) ? ST_FTM : ST_DONE;
                     end else begin
                        kcnt_q <= kcnt_q + 1'b1;
                     end
                  end
               end
            end
            ST_FTM: begin
               if (ftm_beat_c) begin
                  if (fcnt_last) begin
                     if (!s_tlast) begin
                        err_q <= 1'b1;
                     end
                     state_q <= ST_DONE;
                  end else if (s_tlast) begin
                     err_q <= 1'b1;
                  end
               end
            end
            ST_DONE: begin
               state_q     <= ST_IDLE;
               busy_q      <= 1'b0;
               cmd_ready_q <= 1'b1;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign cmd_ready = cmd_ready_q;
   assign s_tready  = tready_c;
   assign para      = para_q;
   assign para_we   = para_we_q;
   assign wb_clr    = wb_clr_q;
   assign wb_we     = wb_we_q;
   assign fb_clr    = fb_clr_q;
   assign fb_we     = fb_we_q;
   assign di        = di_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;

endmodule

// File: tb/tb_conv_loader.sv
// Directed bench for conv_loader: drives commands and the input stream, and
// checks buffer writes, pulses, ordering, error flag and reset behaviour.
module tb_conv_loader;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [63:0] cmd_para = '0;
   logic [19:0] cmd_wei_words = '0;
   logic [19:0] cmd_ftm_words = '0;
   logic        s_tvalid = 1'b0;
   logic        s_tready;
   logic [63:0] s_tdata = '0;
   logic        s_tlast = 1'b0;
   logic [63:0] para;
   logic        para_we, wb_clr, wb_we, fb_clr, fb_we;
   logic [63:0] di;
   logic        wb_full = 1'b0;
   logic        fb_full = 1'b0;
   logic        busy, done, err;

   always #5 clk = ~clk;

   conv_loader #(
      .DATA_WIDTH (64),
      .B_PARA     (64),
      .B_WORDS    (20),
      .N_KERNEL   (4)
   ) dut (
      .clk           (clk),
      .rstn          (rstn),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_para      (cmd_para),
      .cmd_wei_words (cmd_wei_words),
      .cmd_ftm_words (cmd_ftm_words),
      .s_tvalid      (s_tvalid),
      .s_tready      (s_tready),
      .s_tdata       (s_tdata),
      .s_tlast       (s_tlast),
      .para          (para),
      .para_we       (para_we),
      .wb_clr        (wb_clr),
      .wb_we         (wb_we),
      .fb_clr        (fb_clr),
      .fb_we         (fb_we),
      .di            (di),
      .wb_full       (wb_full),
      .fb_full       (fb_full),
      .busy          (busy),
      .done          (done),
      .err           (err)
   );

   int errors = 0;
   int checks = 0;

   // Write/pulse monitor, sampled on the falling edge.
   int          cyc = 0;
   int          wb_n = 0, fb_n = 0, para_n = 0, wclr_n = 0, fclr_n = 0, done_n = 0;
   int          last_fb_cyc = 0, done_cyc = 0;
   logic [63:0] wb_log[$];
   logic [63:0] fb_log[$];
   int          we_cyc[$];

   always @(negedge clk) begin
      cyc++;
      if (wb_we) begin
         wb_n++;
         wb_log.push_back(di);
         we_cyc.push_back(cyc);
      end
      if (fb_we) begin
         fb_n++;
         fb_log.push_back(di);
         we_cyc.push_back(cyc);
         last_fb_cyc = cyc;
      end
      if (para_we) para_n++;
      if (wb_clr) wclr_n++;
      if (fb_clr) fclr_n++;
      if (done) begin
         done_n++;
         done_cyc = cyc;
      end
   end

   int b_wb, b_fb, b_para, b_wclr, b_fclr, b_done, b_we, acc_cyc;

   function automatic logic [63:0] word(input int t, input int i);
      return {8'hD0, 24'(t), 32'(i)};
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic snap();
      b_wb   = wb_n;
      b_fb   = fb_n;
      b_para = para_n;
      b_wclr = wclr_n;
      b_fclr = fclr_n;
      b_done = done_n;
      b_we   = we_cyc.size();
   endtask

   task automatic send_cmd(input int wei, input int ftm, input logic [63:0] p, input logic hold);
      logic r;
      int   k;
      r = 1'b0;
      cmd_valid     = 1'b1;
      cmd_wei_words = 20'(wei);
      cmd_ftm_words = 20'(ftm);
      cmd_para      = p;
      for (k = 0; k < 20; k++) begin
         @(negedge clk);
         r = cmd_ready;
         @(posedge clk);
         #1;
         if (r) break;
      end
      if (!hold) cmd_valid = 1'b0;
      acc_cyc = cyc;
      chk("cmd_accepted", r, 1'b1);
   endtask

   task automatic run_stream(input int t, input int n, input int tlast_at, input logic final_tlast,
                             input int full_at, input int full_len, input int abort_wb);
      int   idx;
      int   left;
      int   k;
      logic rdy;
      logic full_now;
      idx  = 0;
      left = full_len;
      k    = 0;
      while (idx < n && k < 400) begin
         full_now = (idx == full_at) && (left > 0);
         fb_full  = full_now;
         s_tvalid = 1'b1;
         s_tdata  = word(t, idx);
         s_tlast  = (idx == tlast_at) || (final_tlast && (idx == n - 1));
         @(negedge clk);
         rdy = s_tready;
         if (full_now) begin
            left--;
            chk("tready_while_full", rdy, 1'b0);
         end
         @(posedge clk);
         #1;
         if (rdy) idx++;
         k++;
         if (abort_wb > 0 && (wb_n - b_wb) >= abort_wb) break;
      end
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      fb_full  = 1'b0;
      chk("stream_budget", (k < 400), 1'b1);
   endtask

   task automatic wait_done();
      logic seen;
      int   k;
      seen = 1'b0;
      for (k = 0; k < 60; k++) begin
         @(negedge clk);
         if (done) begin
            seen      = 1'b1;
            cmd_valid = 1'b0;
         end
         @(posedge clk);
         #1;
         if (seen) break;
      end
      chk("done_seen", seen, 1'b1);
   endtask

   task automatic check_load(input int t, input int nw, input int nf, input logic exp_err);
      chk("para_we_count", para_n - b_para, 1);
      chk("wb_clr_count", wclr_n - b_wclr, 1);
      chk("fb_clr_count", fclr_n - b_fclr, 1);
      chk("wb_we_count", wb_n - b_wb, nw);
      chk("fb_we_count", fb_n - b_fb, nf);
      chk("done_count", done_n - b_done, 1);
      if (nf > 0) chk("done_after_last_fb", done_cyc - last_fb_cyc, 1);
      chk("err_flag", err, exp_err);
      for (int i = 0; i < nw; i++) chk("wb_data", wb_log[b_wb + i], word(t, i));
      for (int i = 0; i < nf; i++) chk("fb_data", fb_log[b_fb + i], word(t, nw + i));
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("reset_ctrl", {cmd_ready, s_tready, para_we, wb_clr, fb_clr, wb_we, fb_we, busy, done, err}, 10'b0);
      chk("reset_para", para, 64'h0);
      chk("reset_di", di, 64'h0);
      rstn = 1'b1;
      @(posedge clk);
      #1;
      chk("cmd_ready_after_reset", cmd_ready, 1'b1);
      chk("busy_after_reset", busy, 1'b0);

      // 1: 3 words/kernel x 4 kernels + 5 feature words, no backpressure
      snap();
      send_cmd(3, 5, 64'h0000_1234_5678_9A0D, 1'b0);
      chk("busy_in_para", busy, 1'b1);
      chk("cmd_ready_busy", cmd_ready, 1'b0);
      chk("para_value", para, 64'h0000_1234_5678_9A0D);
      run_stream(1, 17, -1, 1'b1, -1, 0, 0);
      wait_done();
      check_load(1, 12, 5, 1'b0);
      chk("first_wb_latency", we_cyc[b_we] - acc_cyc, 3);
      chk("writes_contiguous", we_cyc[b_we + 16] - we_cyc[b_we], 16);
      chk("busy_after_done", busy, 1'b0);
      chk("cmd_ready_after_done", cmd_ready, 1'b1);

      // 2: fb_full held 4 cycles on the third feature beat
      snap();
      send_cmd(3, 5, 64'h0000_0000_0000_0005, 1'b0);
      run_stream(2, 17, -1, 1'b1, 14, 4, 0);
      wait_done();
      check_load(2, 12, 5, 1'b0);
      chk("fb_stall_gap", we_cyc[b_we + 16] - we_cyc[b_we + 12], 8);

      // 3: stray s_tlast on a weight beat sets err, load still completes
      snap();
      send_cmd(3, 5, 64'h0000_0000_0000_000A, 1'b0);
      run_stream(3, 17, 7, 1'b1, -1, 0, 0);
      wait_done();
      check_load(3, 12, 5, 1'b1);

      // 4: no weights, PARA goes straight to FTM; err cleared by new command
      snap();
      send_cmd(0, 2, 64'h0000_0000_0000_0001, 1'b0);
      chk("err_cleared_on_cmd", err, 1'b0);
      run_stream(4, 2, -1, 1'b1, -1, 0, 0);
      wait_done();
      check_load(4, 0, 2, 1'b0);
      chk("first_fb_latency", we_cyc[b_we] - acc_cyc, 3);

      // 5: missing s_tlast on the single final feature beat
      snap();
      send_cmd(0, 1, 64'h0, 1'b0);
      run_stream(5, 1, -1, 1'b0, -1, 0, 0);
      wait_done();
      check_load(5, 0, 1, 1'b1);

      // 6: reset after 6 weight writes, then a clean reload
      snap();
      send_cmd(3, 5, 64'hFFFF_0000_0000_0006, 1'b0);
      run_stream(6, 17, -1, 1'b1, -1, 0, 6);
      chk("abort_point_wb", wb_n - b_wb, 6);
      rstn = 1'b0;
      #1;
      chk("midload_reset_ctrl", {cmd_ready, s_tready, para_we, wb_clr, fb_clr, wb_we, fb_we, busy, done, err}, 10'b0);
      chk("midload_reset_para", para, 64'h0);
      chk("midload_reset_di", di, 64'h0);
      #1;
      rstn = 1'b1;
      @(posedge clk);
      #1;
      chk("cmd_ready_after_rerelease", cmd_ready, 1'b1);
      snap();
      send_cmd(3, 5, 64'h0000_0000_0000_0007, 1'b0);
      run_stream(7, 17, -1, 1'b1, -1, 0, 0);
      wait_done();
      check_load(7, 12, 5, 1'b0);

      // 7: cmd_valid held high across the whole load
      snap();
      send_cmd(1, 1, 64'h0000_0000_0000_0008, 1'b1);
      chk("cmd_ready_low_valid_held", cmd_ready, 1'b0);
      run_stream(8, 5, -1, 1'b1, -1, 0, 0);
      wait_done();
      check_load(8, 4, 1, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      chk("no_second_para", para_n - b_para, 1);
      chk("idle_after_held", busy, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
